// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_pkg
// Brief    : Shared constants and types for the PWM capture Wishbone slave.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

    // Word offsets (byte address [7:2])
    localparam logic [5:0] c_word_ctrl    = 6'h00;
    localparam logic [5:0] c_word_status  = 6'h01;
    localparam logic [5:0] c_word_irq_en  = 6'h02;
    localparam logic [5:0] c_word_level   = 6'h03;
    localparam logic [5:0] c_word_ch_base = 6'h04;

    localparam int c_max_ch     = 8;
    localparam int c_valid_base = 0;
    localparam int c_ovf_base   = 8;
    localparam int c_filt_depth = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_capture_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_wb_if
// Brief    : Wishbone classic slave bundle for the PWM capture unit.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_capture_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/pwm_capture_ch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_ch
// Brief    : One capture channel: sync, optional stability filter
//            (PWM_CAPTURE_GLITCH_FILTER_EN), edge detect, FSM, counters.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture_ch
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_pin,
    output logic                  o_level,
    output logic                  o_valid_set,
    output logic                  o_ovf_set,
    output logic [CNT_W-1:0]      o_period,
    output logic [CNT_W-1:0]      o_high
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             r_sync1, r_sync2, r_lvl, r_pend;
    logic             w_lvl, w_rise, w_fall, w_sat, w_discard;
    logic [CNT_W-1:0] r_per_cnt, r_hi_cnt, r_hi_lat;
    ch_state_t        r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl   <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_lvl   <= w_lvl;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Accept a new level only once it has been seen on the last c_filt_depth samples.
    logic [c_filt_depth-2:0] r_hist;
    logic                    w_stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
        end else begin
            r_hist <= {r_hist[c_filt_depth-3:0], r_sync2};
        end
    end

    always_comb begin
        w_stable = 1'b1;
        for (int i = 0; i < c_filt_depth - 1; i++) begin
            if (r_hist[i] != r_sync2) begin
                w_stable = 1'b0;
            end
        end
        w_lvl = w_stable ? r_sync2 : r_lvl;
    end
`else
    assign w_lvl = r_sync2;
`endif

    assign w_rise      = w_lvl & ~r_lvl;
    assign w_fall      = ~w_lvl & r_lvl;
    assign w_sat       = (r_per_cnt == c_cnt_max) || (r_hi_cnt == c_cnt_max);
    assign w_discard   = r_pend | w_sat;
    assign o_level     = r_lvl;
    assign o_valid_set = i_en && (r_state == ST_MEASURE) && w_rise && !w_discard;
    assign o_ovf_set   = i_en && (r_state == ST_MEASURE) && !r_pend && w_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_hi_lat  <= '0;
            r_pend    <= 1'b0;
            o_period  <= '0;
            o_high    <= '0;
        end else if (!i_en) begin
            r_state   <= ST_IDLE;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_hi_lat  <= '0;
            r_pend    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_ARMED;
                ST_ARMED: begin
                    if (w_rise) begin
                        r_state   <= ST_MEASURE;
                        r_per_cnt <= c_cnt_one;
                        r_hi_cnt  <= c_cnt_one;
                        r_hi_lat  <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        // A period that saturated anywhere is dropped, not reported.
                        if (!w_discard) begin
                            o_period <= r_per_cnt;
                            o_high   <= r_hi_lat;
                        end
                        r_per_cnt <= c_cnt_one;
                        r_hi_cnt  <= c_cnt_one;
                        r_hi_lat  <= '0;
                        r_pend    <= 1'b0;
                    end else begin
                        if (r_per_cnt != c_cnt_max) begin
                            r_per_cnt <= r_per_cnt + c_cnt_one;
                        end
                        if (w_lvl && (r_hi_cnt != c_cnt_max)) begin
                            r_hi_cnt <= r_hi_cnt + c_cnt_one;
                        end
                        if (w_fall) begin
                            r_hi_lat <= r_hi_cnt;
                        end
                        if (w_sat) begin
                            r_pend <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_capture_wb.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture_wb
// Brief    : Wishbone PWM period/high-time capture unit, up to 8 channels.
//            Optional glitch filter: PWM_CAPTURE_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture_wb
    import pwm_capture_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 24
) (
    input  wire logic              wb_clk_i,
    input  wire logic              wb_rst_i,
    pwm_capture_wb_if.slave        wb,
    input  wire logic [NUM_CH-1:0] pwm_in,
    output logic                   irq
);

    localparam logic [7:0] c_ch_mask = 8'((9'd1 << NUM_CH) - 9'd1);

    logic        r_ack;
    logic [31:0] r_dat;
    logic [7:0]  r_ctrl;
    logic [15:0] r_status, r_irq_en;

    logic        w_acc, w_wr, w_rd, w_unused;
    logic [5:0]  w_word, w_ch_word;
    logic [15:0] w_wmask, w_w1c, w_hw_set;
    logic [31:0] w_rdata;
    logic [7:0]  w_valid_set, w_ovf_set, w_level;
    logic [31:0] w_period [c_max_ch];
    logic [31:0] w_high   [c_max_ch];

    assign w_acc     = wb.wbs_stb_i & wb.wbs_cyc_i & ~r_ack;
    assign w_wr      = w_acc & wb.wbs_we_i;
    assign w_rd      = w_acc & ~wb.wbs_we_i;
    assign w_word    = wb.wbs_adr_i[7:2];
    assign w_ch_word = w_word - c_word_ch_base;
    assign w_wmask   = {{8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};
    assign w_w1c     = (w_wr && (w_word == c_word_status)) ? (wb.wbs_dat_i[15:0] & w_wmask) : 16'd0;
    assign w_unused  = ^{wb.wbs_adr_i[31:8], wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:16], wb.wbs_sel_i[3:2]};

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;

    for (genvar i = 0; i < c_max_ch; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            logic [CNT_W-1:0] w_per, w_hi;
            pwm_capture_ch #(.CNT_W(CNT_W)) u_ch (
                .clk         (wb_clk_i),
                .rst         (wb_rst_i),
                .i_en        (r_ctrl[i]),
                .i_pin       (pwm_in[i]),
                .o_level     (w_level[i]),
                .o_valid_set (w_valid_set[i]),
                .o_ovf_set   (w_ovf_set[i]),
                .o_period    (w_per),
                .o_high      (w_hi)
            );
            assign w_period[i] = 32'(w_per);
            assign w_high[i]   = 32'(w_hi);
        end else begin : g_off
            assign w_level[i]     = 1'b0;
            assign w_valid_set[i] = 1'b0;
            assign w_ovf_set[i]   = 1'b0;
            assign w_period[i]    = 32'd0;
            assign w_high[i]      = 32'd0;
        end
    end

    always_comb begin
        w_hw_set = '0;
        w_hw_set[c_valid_base +: 8] = w_valid_set;
        w_hw_set[c_ovf_base +: 8]   = w_ovf_set;
    end

    // Channel slots past NUM_CH are tied to zero, so only the window bound matters here.
    always_comb begin
        w_rdata = 32'd0;
        case (w_word)
            c_word_ctrl:   w_rdata = {24'd0, r_ctrl};
            c_word_status: w_rdata = {16'd0, r_status};
            c_word_irq_en: w_rdata = {16'd0, r_irq_en};
            c_word_level:  w_rdata = {24'd0, w_level};
            default: begin
                if ((w_word >= c_word_ch_base) && (w_ch_word < 6'(2 * c_max_ch))) begin
                    w_rdata = w_ch_word[0] ? w_high[w_ch_word[3:1]] : w_period[w_ch_word[3:1]];
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_ctrl   <= 8'd0;
            r_status <= 16'd0;
            r_irq_en <= 16'd0;
            irq      <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_rd ? w_rdata : 32'd0;
            if (w_wr && (w_word == c_word_ctrl)) begin
                r_ctrl <= ((r_ctrl & ~w_wmask[7:0]) | (wb.wbs_dat_i[7:0] & w_wmask[7:0])) & c_ch_mask;
            end
            if (w_wr && (w_word == c_word_irq_en)) begin
                r_irq_en <= ((r_irq_en & ~w_wmask) | (wb.wbs_dat_i[15:0] & w_wmask))
                            & {c_ch_mask, c_ch_mask};
            end
            // Hardware set beats a simultaneous write-1-to-clear.
            r_status <= (r_status & ~w_w1c) | w_hw_set;
            irq      <= |(r_status & r_irq_en);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture_wb
// Brief    : Directed self-checking bench for pwm_capture_wb (CNT_W = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture_wb;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int c_lat = 4;
`else
    localparam int c_lat = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pwm_in = 8'd0;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    pwm_capture_wb_if wb_if ();

    pwm_capture_wb #(.NUM_CH(8), .CNT_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (wb_if),
        .pwm_in   (pwm_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          per;
        int          hi;
        logic [31:0] exp_per;
        logic [31:0] exp_hi;
        logic [31:0] exp_status;
    } meas_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    meas_vec_t mv [6];
    rd_vec_t   rv [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_if.wbs_ack_o && n < 8);
        checks++;
        if (!wb_if.wbs_ack_o) begin
            errors++;
            $display("FAIL ack_timeout: got ack=0 after %0d cycles, expected ack=1", n);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_if.wbs_adr_i = a;
        wb_if.wbs_dat_i = d;
        wb_if.wbs_sel_i = s;
        wb_if.wbs_we_i  = 1'b1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wait_ack();
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        wb_if.wbs_adr_i = a;
        wb_if.wbs_sel_i = 4'hF;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wait_ack();
        d = wb_if.wbs_dat_o;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        check(name, d, exp);
    endtask

    // n periods of p cycles with h high cycles; call just after a clock edge.
    task automatic pulse_train(input int ch, input int p, input int h, input int n);
        for (int r = 0; r < n; r++) begin
            pwm_in[ch] = 1'b1;
            repeat (h) @(posedge clk);
            #1;
            pwm_in[ch] = 1'b0;
            repeat (p - h) @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_reads(input string tag);
        for (int i = 0; i < 21; i++) begin
            read_check($sformatf("%s_rd_%02h", tag, rv[i].addr), rv[i].addr, rv[i].exp);
        end
        check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;

        mv[0] = '{ch: 0, per: 100, hi: 25, exp_per: 32'd100, exp_hi: 32'd25, exp_status: 32'h0001};
        mv[1] = '{ch: 1, per: 37,  hi: 3,  exp_per: 32'd37,  exp_hi: 32'd3,  exp_status: 32'h0002};
        mv[2] = '{ch: 2, per: 10,  hi: 7,  exp_per: 32'd10,  exp_hi: 32'd7,  exp_status: 32'h0004};
        mv[3] = '{ch: 3, per: 60,  hi: 30, exp_per: 32'd60,  exp_hi: 32'd30, exp_status: 32'h0008};
        mv[4] = '{ch: 5, per: 150, hi: 75, exp_per: 32'd150, exp_hi: 32'd75, exp_status: 32'h0020};
        mv[5] = '{ch: 7, per: 6,   hi: 3,  exp_per: 32'd6,   exp_hi: 32'd3,  exp_status: 32'h0080};
        for (int i = 0; i < 20; i++) begin
            rv[i] = '{addr: 32'(i * 4), exp: 32'd0};
        end
        rv[20] = '{addr: 32'h90, exp: 32'd0};

        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_sel_i = 4'h0;
        wb_if.wbs_dat_i = 32'd0;
        wb_if.wbs_adr_i = 32'd0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        reset_reads("rst");
        @(posedge clk);
        #1;
        check("dat_idle", wb_if.wbs_dat_o, 32'd0);

        // Table-driven measurements
        for (int i = 0; i < 6; i++) begin
            wb_write(32'h04, 32'hFFFF, 4'hF);
            wb_write(32'h08, 32'(1) << mv[i].ch, 4'hF);
            wb_write(32'h00, 32'(1) << mv[i].ch, 4'hF);
            pulse_train(mv[i].ch, mv[i].per, mv[i].hi, 2);
            read_check($sformatf("v%0d_period", i), 32'h10 + 32'(8 * mv[i].ch), mv[i].exp_per);
            read_check($sformatf("v%0d_high", i), 32'h14 + 32'(8 * mv[i].ch), mv[i].exp_hi);
            read_check($sformatf("v%0d_status", i), 32'h04, mv[i].exp_status);
            check($sformatf("v%0d_irq", i), {31'd0, irq}, 32'd1);
            wb_write(32'h04, 32'(1) << mv[i].ch, 4'hF);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_irq_clr", i), {31'd0, irq}, 32'd0);
            wb_write(32'h00, 32'd0, 4'hF);
        end

        // Overflow on channel 3: a long low period saturates and is discarded
        wb_write(32'h04, 32'hFFFF, 4'hF);
        wb_write(32'h08, 32'd0, 4'hF);
        wb_write(32'h00, 32'h08, 4'hF);
        pulse_train(3, 310, 10, 1);
        read_check("ovf_status", 32'h04, 32'h0800);
        read_check("ovf_period_kept", 32'h28, 32'd60);
        pulse_train(3, 50, 10, 2);
        read_check("ovf_rec_period", 32'h28, 32'd50);
        read_check("ovf_rec_high", 32'h2C, 32'd10);
        read_check("ovf_rec_status", 32'h04, 32'h0808);
        wb_write(32'h00, 32'd0, 4'hF);

        // First edge while already high, then disable and re-enable on channel 0
        wb_write(32'h04, 32'hFFFF, 4'hF);
        pwm_in[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        wb_write(32'h00, 32'h01, 4'hF);
        repeat (10) @(posedge clk);
        #1;
        read_check("fe_level", 32'h0C, 32'h01);
        read_check("fe_no_valid_high", 32'h04, 32'h0);
        pwm_in[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        pulse_train(0, 40, 15, 1);
        read_check("fe_no_valid_1rise", 32'h04, 32'h0);
        read_check("fe_period_kept", 32'h10, 32'd100);
        pulse_train(0, 30, 10, 2);
        read_check("fe_period", 32'h10, 32'd30);
        read_check("fe_high", 32'h14, 32'd10);
        read_check("fe_status", 32'h04, 32'h0001);
        wb_write(32'h04, 32'h0001, 4'hF);
        wb_write(32'h00, 32'h00, 4'hF);
        pulse_train(0, 20, 5, 3);
        read_check("dis_period_kept", 32'h10, 32'd30);
        read_check("dis_status", 32'h04, 32'h0);
        wb_write(32'h00, 32'h01, 4'hF);
        pulse_train(0, 20, 5, 1);
        read_check("reen_no_valid", 32'h04, 32'h0);
        pulse_train(0, 24, 6, 2);
        read_check("reen_period", 32'h10, 32'd24);
        read_check("reen_high", 32'h14, 32'd6);
        read_check("reen_status", 32'h04, 32'h0001);

        // W1C of VALID[0] lands on the same edge as a fresh capture
        pwm_in[0] = 1'b1;
        repeat (c_lat) @(posedge clk);
        #1;
        wb_write(32'h04, 32'h0001, 4'hF);
        read_check("race_valid_kept", 32'h04, 32'h0001);
        wb_write(32'h04, 32'h0001, 4'hF);
        read_check("w1c_clears", 32'h04, 32'h0);

        // Byte lanes and unmapped addresses
        wb_write(32'h00, 32'hFF, 4'h0);
        read_check("sel0_ctrl", 32'h00, 32'h01);
        wb_write(32'h08, 32'h0000_AB12, 4'h2);
        read_check("sel_byte1", 32'h08, 32'h0000_AB00);
        wb_write(32'h08, 32'hFFFF_FFFF, 4'h1);
        read_check("sel_byte0", 32'h08, 32'h0000_ABFF);
        wb_write(32'h08, 32'h0, 4'hF);
        wb_write(32'h90, 32'hFFFF_FFFF, 4'hF);
        read_check("unmapped_90", 32'h90, 32'h0);
        read_check("unmapped_50", 32'h50, 32'h0);
        read_check("unmapped_wr_ctrl", 32'h00, 32'h01);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        // Short glitch is swallowed, 3-cycle pulse survives
        wb_write(32'h04, 32'hFFFF, 4'hF);
        wb_write(32'h00, 32'h02, 4'hF);
        pwm_in[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pwm_in[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        read_check("filt_glitch", 32'h04, 32'h0);
        pulse_train(1, 20, 3, 1);
        read_check("filt_arm_only", 32'h04, 32'h0);
        pulse_train(1, 20, 3, 2);
        read_check("filt_period", 32'h18, 32'd20);
        read_check("filt_high", 32'h1C, 32'd3);
`endif

        // Reset in the middle of a measurement
        pwm_in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_reads("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_capture_wb.md
# pwm_capture_wb

Wishbone-slave PWM capture unit that measures period and high time of up to eight PWM waveforms, cycle-exact in `wb_clk_i` cycles. It sits downstream of the timer/PWM peripherals on the user-project Wishbone bus splitter and consumes the `pwm_out` bus for closed-loop self-check and duty monitoring. The host reads results over Wishbone and gets an optional interrupt per completed measurement.

## Interface
- `NUM_CH`, 8: number of capture channels, 1..8.
- `CNT_W`, 24: counter and result width, 8..32. Results are zero-extended to 32 bits.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone classic slave controls.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_dat_i` in 32: write data.
- `wbs_adr_i` in 32: byte address. Only `[7:2]` is decoded.
- `wbs_ack_o` out 1: registered acknowledge.
- `wbs_dat_o` out 32: registered read data.
- `pwm_in` in NUM_CH: asynchronous PWM inputs.
- `irq` out 1: registered, level-high interrupt.

## Operation
- Register map, byte offsets:
  - 0x00 CTRL RW, `[NUM_CH-1:0]` channel enable.
  - 0x04 STATUS: `[7:0]` VALID, `[15:8]` OVF. Write-1-to-clear.
  - 0x08 IRQ_EN RW, same bit layout as STATUS.
  - 0x0C LEVEL RO, filtered synchronized levels.
  - 0x10+8i PERIOD_i RO.
  - 0x14+8i HIGH_i RO.
- Unmapped offsets and channels ≥ NUM_CH read 0. Writes to them are ignored.
- RW writes honour `wbs_sel_i` byte lanes.
- Per-channel front end: 2-FF synchronizer, then an edge detector (previous-level register). Rise and fall are single-cycle strobes.
- Per-channel state: IDLE (disabled) → ARMED (enabled, waiting for the first rise) → MEASURE.
- Counters `per_cnt` and `hi_cnt` are CNT_W wide.
- In MEASURE:
  - `per_cnt` increments every cycle.
  - `hi_cnt` increments while the level is high.
  - On fall, latch `hi_lat <= hi_cnt`.
- Rise in ARMED: go to MEASURE with `per_cnt = hi_cnt = 1`. No capture.
- Rise in MEASURE, no overflow pending: `PERIOD_i <= per_cnt`, `HIGH_i <= hi_lat`, set VALID[i], then reload both counters to 1.
- A counter reaching 2^CNT_W−1 saturates, sets OVF[i] and marks overflow pending.
- The next rise after an overflow discards the measurement: no PERIOD/HIGH update, no VALID. It clears pending and reloads the counters.
- Input constantly low: HIGH reads 0 after recovery. Constantly high: OVF.
- Clearing CTRL[i] → IDLE immediately. Counters and pending are cleared. PERIOD/HIGH/STATUS are retained.
- A hardware set of VALID/OVF in the same cycle as a W1C to that bit: set wins.
- `irq <= |(STATUS & IRQ_EN)` over bits `[15:0]`.
- Reset values: all outputs 0, all registers 0, all channels IDLE.

## Timing
- Wishbone:
  - `wbs_ack_o <= wbs_stb_i & wbs_cyc_i & ~wbs_ack_o`, i.e. one wait state and a one-cycle ack pulse.
  - `wbs_dat_o` is valid with ack and is 0 otherwise.
  - A write takes effect on the ack edge.
- Input latency: a pin transition first sampled at clock edge k reaches PERIOD/HIGH/STATUS at edge k+2. `irq` follows at edge k+3.
- Latency is identical for rise and fall, so results are exact to ±1 cycle of sampling quantization. With synchronous stimulus they are exact.
- `wb_rst_i` mid-measurement: everything returns to reset on the next edge and the in-flight measurement is lost.

## Configuration
- Macro `PWM_CAPTURE_GLITCH_FILTER_EN`.
- Defined: a per-channel stability filter after the synchronizer accepts a new level only after 3 consecutive equal samples. This adds 2 cycles of latency (state changes at k+4) and suppresses pulses shorter than 3 cycles. LEVEL reports the filtered value.
- Not defined: the synchronizer output feeds the edge detector directly.

## Structure
- Package `pwm_capture_pkg` holds:
  - register offset constants;
  - STATUS bit-field positions (VALID base 0, OVF base 8);
  - the channel state enum (IDLE/ARMED/MEASURE);
  - the filter depth constant (3).
- Sub-module `pwm_capture_ch` covers sync, optional filter, edge detect, state machine, counters and the capture registers. It has VALID/OVF set strobes and is instantiated NUM_CH times by generate.
- The top level holds the Wishbone decode, CTRL/STATUS/IRQ_EN, the read mux and `irq`.

## Test plan
- Reset: after `wb_rst_i` held 2 cycles, reads of every register return 0, and `irq=0`, `wbs_ack_o=0`.
- Basic measurement, channel 0: CTRL=0x01, IRQ_EN=0x01, `pwm_in[0]` with period 100 and high 25, synchronous. After the 2nd rise: PERIOD_0=100, HIGH_0=25, STATUS=0x0001, `irq=1`. Writing STATUS=0x0001 clears `irq` next cycle.
- First edge and disable: enable mid-high, no VALID until the 2nd rise. Disabling mid-period retains the old PERIOD and returns the channel to IDLE; re-enable needs 2 rises again.
- Overflow, CNT_W=8: hold `pwm_in[3]` low 300 cycles → OVF[3] (STATUS=0x0800), PERIOD_3 unchanged. The next full 50/10 period yields PERIOD_3=50, HIGH_3=10.
- Race and byte lanes:
  - W1C of VALID[0] in the same cycle as a new capture leaves VALID[0]=1.
  - A CTRL write 0xFF with `wbs_sel_i=0x0` changes nothing.
  - Read of 0x90 returns 0.
- Filter (macro defined): a 2-cycle high glitch causes no edge. A 3-cycle high pulse gives HIGH=3.
